// File: rtl/udp_jpeg_frag_sched.sv
// udp_jpeg_frag_sched
// Splits one JPEG frame held in DDR into UDP-sized fragments and sequences
// the 128-bit UDP sender one fragment at a time. The steps are: load the
// fragment descriptor, issue a start pulse, wait for the sender to accept,
// wait for it to finish, then insert an inter-fragment gap.
// The optional macro UDP_FRAG_STATS_EN enables the o_frag_total and
// o_err_cnt statistics counters. Without it both ports are tied to 0.
// SIGN_INIT sets the IPv4 identification value that the first fragment
// after reset carries.
module udp_jpeg_frag_sched #(
  parameter int unsigned MAX_PAYLOAD = 1024,
  parameter int unsigned GAP_CYCLES  = 50,
  parameter logic [15:0] SIGN_INIT   = 16'h0000
) (
  input  logic        i_udp_clk50m,
  input  logic        i_rst,
  input  logic        i_frame_start,
  input  logic [23:0] i_frame_len,
  input  logic        i_abort,
  output logic        o_frame_busy,
  output logic        o_frame_done,
  output logic        o_send_en,
  output logic        o_last_frame_flag,
  output logic [14:0] o_frame_rank,
  output logic [15:0] o_jpeg_len,
  output logic [15:0] o_ipv4_sign,
  output logic [23:0] o_frag_offset,
  input  logic        i_send_busy,
  input  logic        i_send_frame_down,
  output logic [31:0] o_frag_total,
  output logic [15:0] o_err_cnt
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] ISSUE     = 3'd2;
  localparam logic [2:0] WAIT_ACK  = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
  localparam logic [2:0] GAP       = 3'd5;

  localparam logic [23:0] MAX_P24  = 24'(MAX_PAYLOAD);
  localparam logic [15:0] MAX_P16  = 16'(MAX_PAYLOAD);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam bit          GAP_EN   = (GAP_CYCLES != 0);

  // Payload size of the fragment starting at the given remaining byte count.
  function automatic logic [15:0] frag_len_of(input logic [23:0] rem);
    frag_len_of = (rem > MAX_P24) ? MAX_P16 : rem[15:0];
  endfunction

  logic [2:0]  state;
  logic [23:0] remaining;
  logic [14:0] rank;
  logic [23:0] offset;
  logic [15:0] sign;
  logic        busy_r;
  logic        done_r;
  logic        send_en_r;
  logic [3:0]  ack_cnt;
  logic [15:0] gap_cnt;
  logic        abort_pend;

  logic [15:0] frag_len;
  logic        last_frag;
  logic        abort_now;
  logic        ack_timeout;

  // Descriptor of the current fragment and the event decodes the FSM uses.
  always_comb begin
    frag_len    = frag_len_of(remaining);
    last_frag   = (remaining <= MAX_P24);
    abort_now   = abort_pend | i_abort;
    ack_timeout = (state == WAIT_ACK) && !i_send_busy && (ack_cnt == 4'hF);
  end

  // Fragment sequencer: frame acceptance, issue/ack/done handshake, gap timing.
  always_ff @(posedge i_udp_clk50m or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      remaining  <= '0;
      rank       <= '0;
      offset     <= '0;
      sign       <= SIGN_INIT;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      send_en_r  <= 1'b0;
      ack_cnt    <= '0;
      gap_cnt    <= '0;
      abort_pend <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      send_en_r <= 1'b0;
      case (state)
        IDLE: begin
          if (i_frame_start) begin
            if (i_frame_len != 24'd0) begin
              remaining  <= i_frame_len;
              rank       <= '0;
              offset     <= '0;
              busy_r     <= 1'b1;
              abort_pend <= 1'b0;
              state      <= LOAD;
            end else begin
              // An empty frame completes immediately without touching the sender.
              done_r <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (i_abort) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_abort) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            send_en_r <= 1'b1;
            ack_cnt   <= '0;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (i_abort) begin
            abort_pend <= 1'b1;
          end
          if (i_send_busy) begin
            state <= WAIT_DONE;
          end else if (ack_timeout) begin
            // Sender never accepted: reissue unless the frame was cancelled meanwhile.
            if (abort_now) begin
              busy_r <= 1'b0;
              state  <= IDLE;
            end else begin
              state <= ISSUE;
            end
          end else begin
            ack_cnt <= ack_cnt + 4'd1;
          end
        end
        WAIT_DONE: begin
          if (i_abort) begin
            abort_pend <= 1'b1;
          end
          if (!i_send_busy) begin
            remaining <= remaining - {8'd0, frag_len};
            offset    <= offset + {8'd0, frag_len};
            rank      <= rank + 15'd1;
            sign      <= sign + 16'd1;
            if (last_frag || abort_now) begin
              busy_r <= 1'b0;
              done_r <= last_frag && !abort_now;
              state  <= IDLE;
            end else if (GAP_EN) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              state <= LOAD;
            end
          end
        end
        GAP: begin
          if (i_abort) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else if (gap_cnt == GAP_LAST) begin
            state <= LOAD;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Descriptor outputs read zero whenever no frame is in flight.
  always_comb begin
    o_frame_busy      = busy_r;
    o_frame_done      = done_r;
    o_send_en         = send_en_r;
    o_last_frame_flag = busy_r & last_frag;
    o_jpeg_len        = busy_r ? frag_len : 16'd0;
    o_frame_rank      = busy_r ? rank : 15'd0;
    o_ipv4_sign       = busy_r ? sign : 16'd0;
    o_frag_offset     = busy_r ? offset : 24'd0;
  end

`ifdef UDP_FRAG_STATS_EN
  // Error counter stops at all-ones rather than wrapping back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0] frag_total;
  logic [15:0] err_cnt;
  logic        down_seen;
  logic        frag_end;
  logic        miss_down;

  // Fragment-end and missing-frame_down decodes for the statistics.
  always_comb begin
    frag_end  = (state == WAIT_DONE) && !i_send_busy;
    miss_down = frag_end && !(down_seen | i_send_frame_down);
  end

  // Statistics counters plus the frame_down capture for the active fragment.
  always_ff @(posedge i_udp_clk50m or posedge i_rst) begin
    if (i_rst) begin
      frag_total <= '0;
      err_cnt    <= '0;
      down_seen  <= 1'b0;
    end else begin
      if (state == WAIT_DONE) begin
        down_seen <= down_seen | i_send_frame_down;
      end else begin
        down_seen <= 1'b0;
      end
      if (frag_end) begin
        frag_total <= frag_total + 32'd1;
      end
      if (ack_timeout || miss_down) begin
        err_cnt <= sat_inc16(err_cnt);
      end
    end
  end

  assign o_frag_total = frag_total;
  assign o_err_cnt    = err_cnt;
`else
  // Without statistics the frame_down pulse has no consumer.
  logic unused_frame_down;
  assign unused_frame_down = i_send_frame_down;
  assign o_frag_total      = 32'd0;
  assign o_err_cnt         = 16'd0;
`endif

endmodule
